// File: rtl/rv32_pkg.sv
// Shared definitions for the priRV32 fetch front-end.
//   XLEN          : architectural register / address width
//   RV32_RESET_PC : default PC loaded on reset
//   fetch_entry_t : one buffered fetch result {pc, inst}
//   word_align()  : clears the byte-offset bits of an address
package rv32_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_ibuf.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst     : clock, synchronous active-high reset (clears storage too)
//   flush        : empties the FIFO; wins over push and pop
//   push, wdata  : write an entry (accepted when not full, or full with pop)
//   pop          : drop the head entry (ignored when empty)
//   head         : entry at the FIFO head, read straight from storage
//   count        : number of valid entries
//   full, empty  : status flags
module rv32_ibuf
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// Instruction fetch front-end: owns the PC, issues in-order word requests to
// instruction memory, buffers responses with their PCs and hands them to decode.
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : request channel to instruction memory
//   imem_rsp_valid/data              : in-order responses, no backpressure
//   redirect_valid/pc                : flush and restart fetch at a new PC
//   inst_valid/ready, inst_data/pc   : instruction channel to decode
module rv32_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV32_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Every word in flight already owns a FIFO slot, so responses never stall.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    assign rsp_drop   = (discard != '0);
    // A response arriving with a redirect belongs to the old stream.
    assign push       = imem_rsp_valid && !rsp_drop && !redirect_valid && !rst;
    assign pop        = inst_valid && inst_ready;
    assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

    rv32_ibuf #(.DEPTH(DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= word_align(RESET_PC);
            rsp_pc      <= word_align(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc      <= word_align(redirect_pc);
                rsp_pc  <= word_align(redirect_pc);
                // Everything still unanswered after this edge is stale.
                discard <= outstanding_next;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid) begin
                    if (rsp_drop) begin
                        discard <= discard - 1'b1;
                    end else begin
                        rsp_pc <= rsp_pc + 32'd4;
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && outstanding == '0));
            assert (credit_used <= (CW+1)'(DEPTH));
            assert (discard <= outstanding);
            assert (!(push && fifo_full && !pop));
        end
    end
`endif

endmodule

// File: tb/tb_rv32_fetch.sv
module tb_rv32_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rst0, rst1;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        inst_ready     = 1'b1;

    logic        rqv0, rqv1, iv0, iv1;
    logic [31:0] rqa0, rqa1, id0, id1, ip0, ip1;
    logic        req_valid, inst_valid;
    logic [31:0] req_addr, inst_data, inst_pc;

    int          cyc = 0;
    int          lat = 1;
    int          rel_cyc, redir_cyc;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];
    int          pop_cyc[$];
    logic [31:0] maddr[$];
    int          mdue[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Only the selected DUT runs; the other is held in reset.
    assign rst0 = sel ? 1'b1 : rst;
    assign rst1 = sel ? rst : 1'b1;
    assign req_valid  = sel ? rqv1 : rqv0;
    assign req_addr   = sel ? rqa1 : rqa0;
    assign inst_valid = sel ? iv1 : iv0;
    assign inst_data  = sel ? id1 : id0;
    assign inst_pc    = sel ? ip1 : ip0;

    rv32_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut0 (
        .clk(clk), .rst(rst0),
        .imem_req_valid(rqv0), .imem_req_ready(imem_req_ready), .imem_req_addr(rqa0),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(iv0), .inst_ready(inst_ready), .inst_data(id0), .inst_pc(ip0)
    );

    rv32_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst1),
        .imem_req_valid(rqv1), .imem_req_ready(imem_req_ready), .imem_req_addr(rqa1),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(iv1), .inst_ready(inst_ready), .inst_data(id1), .inst_pc(ip1)
    );

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Monitor: log accepted requests and pops; feed the memory model.
    always @(negedge clk) begin
        if (rst) begin
            maddr.delete();
            mdue.delete();
        end else begin
            if (req_valid && imem_req_ready) begin
                maddr.push_back(req_addr);
                mdue.push_back(cyc + lat);
                req_log.push_back(req_addr);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                pop_pc.push_back(inst_pc);
                pop_data.push_back(inst_data);
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Memory: fixed latency, in order, answers even after a redirect.
    always @(posedge clk) begin
        #1;
        if (mdue.size() > 0 && mdue[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = fdata(maddr[0]);
            void'(maddr.pop_front());
            void'(mdue.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic clear_logs;
        req_log.delete();
        pop_pc.delete();
        pop_data.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset(input logic s, input int l);
        @(posedge clk); #1;
        rst = 1'b1;
        sel = s;
        lat = l;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_rst;
        @(posedge clk); #1;
        rst = 1'b0;
        rel_cyc = cyc;
        clear_logs();
    endtask

    task automatic wait_pops(input int n, input int limit);
        int k = 0;
        while (pop_pc.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (pop_pc.size() < n) begin
            errors++;
            $display("FAIL pop_timeout: got %0d pops, want %0d", pop_pc.size(), n);
        end
    endtask

    task automatic wait_reqs(input int n, input int limit);
        int k = 0;
        while (req_log.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_log.size() < n) begin
            errors++;
            $display("FAIL req_timeout: got %0d requests, want %0d", req_log.size(), n);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL %s req_valid: got %b want 0", tag, req_valid); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL %s inst_valid: got %b want 0", tag, inst_valid); end
        checks++;
        if (inst_data !== 32'h0) begin errors++; $display("FAIL %s inst_data: got %h want 0", tag, inst_data); end
        checks++;
        if (inst_pc !== 32'h0) begin errors++; $display("FAIL %s inst_pc: got %h want 0", tag, inst_pc); end
    endtask

    task automatic test_reset;
        do_reset(1'b0, 1);
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    task automatic test_stream;
        release_rst();
        wait_pops(3, 20);
        wait_reqs(4, 20);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_log[i] !== 32'(i * 4)) begin
                errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, req_log[i], 32'(i * 4));
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_pc[i] !== 32'(i * 4) || pop_data[i] !== fdata(32'(i * 4))) begin
                errors++; $display("FAIL stream_pop[%0d]: got pc=%h data=%h want pc=%h data=%h",
                                   i, pop_pc[i], pop_data[i], 32'(i * 4), fdata(32'(i * 4)));
            end
        end
        // First instruction visible two cycles after release, next one right behind.
        checks++;
        if (pop_cyc[0] != rel_cyc + 2) begin
            errors++; $display("FAIL stream_fill: got cycle %0d want %0d", pop_cyc[0], rel_cyc + 2);
        end
        checks++;
        if (pop_cyc[1] != rel_cyc + 3) begin
            errors++; $display("FAIL stream_second: got cycle %0d want %0d", pop_cyc[1], rel_cyc + 3);
        end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0, 1);
        inst_ready = 1'b0;
        release_rst();
        repeat (10) @(negedge clk);
        checks++;
        if (req_log.size() != 2) begin
            errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size());
        end
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
        checks++;
        if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b want 1", inst_valid); end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        wait_pops(2, 10);
        wait_reqs(3, 10);
        checks++;
        if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4) begin
            errors++; $display("FAIL bp_pop_order: got %h,%h want 00000000,00000004", pop_pc[0], pop_pc[1]);
        end
        checks++;
        if (req_log[2] !== 32'h8) begin errors++; $display("FAIL bp_resume: got %h want 00000008", req_log[2]); end
    endtask

    task automatic test_req_stall;
        do_reset(1'b0, 1);
        imem_req_ready = 1'b0;
        release_rst();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h want valid=1 addr=0", i, req_valid, req_addr);
            end
        end
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_log.size() < 1 || req_log[0] !== 32'h0 || req_addr !== 32'h4) begin
            errors++; $display("FAIL stall_advance: got first=%h now=%h want first=0 now=4",
                               (req_log.size() > 0) ? req_log[0] : 32'hx, req_addr);
        end
    endtask

    task automatic test_redirect_late;
        do_reset(1'b0, 3);
        release_rst();
        wait_reqs(4, 30);
        checks++;
        if (req_log[2] !== 32'h8 || req_log[3] !== 32'hC) begin
            errors++; $display("FAIL late_setup: got %h,%h want 00000008,0000000c", req_log[2], req_log[3]);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        clear_logs();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_pops(1, 30);
        checks++;
        if (pop_pc[0] !== 32'h100 || pop_data[0] !== fdata(32'h100)) begin
            errors++; $display("FAIL late_first: got pc=%h data=%h want pc=00000100 data=%h",
                               pop_pc[0], pop_data[0], fdata(32'h100));
        end
        checks++;
        if (req_log[0] !== 32'h100) begin errors++; $display("FAIL late_addr: got %h want 00000100", req_log[0]); end
    endtask

    task automatic test_redirect_collide;
        do_reset(1'b0, 1);
        release_rst();
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        redir_cyc      = cyc;
        clear_logs();
        @(negedge clk);
        checks++;
        if (imem_rsp_valid !== 1'b1 || inst_valid !== 1'b1) begin
            errors++; $display("FAIL collide_setup: got rsp=%b inst_valid=%b want 1,1", imem_rsp_valid, inst_valid);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_flush: got inst_valid=%b want 0", inst_valid); end
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h200) begin
            errors++; $display("FAIL collide_addr: got valid=%b addr=%h want 1,00000200", req_valid, req_addr);
        end
        wait_pops(2, 20);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pop_pc[i] !== 32'h200 + 32'(i * 4) || pop_data[i] !== fdata(32'h200 + 32'(i * 4))) begin
                errors++; $display("FAIL collide_pop[%0d]: got pc=%h data=%h want pc=%h", i, pop_pc[i], pop_data[i],
                                   32'h200 + 32'(i * 4));
            end
        end
        // Redirect edge is redir_cyc+1; the first word is consumed two edges later.
        checks++;
        if (pop_cyc[0] != redir_cyc + 3) begin
            errors++; $display("FAIL collide_latency: got cycle %0d want %0d", pop_cyc[0], redir_cyc + 3);
        end
    endtask

    task automatic test_wrap_and_reset;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        do_reset(1'b1, 1);
        release_rst();
        wait_pops(2, 20);
        wait_reqs(3, 20);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log[i] !== exp_addr[i]) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, req_log[i], exp_addr[i]);
            end
        end
        checks++;
        if (pop_pc[1] !== 32'hFFFF_FFFC || pop_data[1] !== fdata(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_pop: got pc=%h data=%h want pc=fffffffc", pop_pc[1], pop_data[1]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        release_rst();
        wait_pops(1, 20);
        checks++;
        if (req_log[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL restart_addr: got %h want fffffff8", req_log[0]); end
        checks++;
        if (pop_pc[0] !== 32'hFFFF_FFF8 || pop_data[0] !== fdata(32'hFFFF_FFF8)) begin
            errors++; $display("FAIL restart_pop: got pc=%h data=%h want pc=fffffff8", pop_pc[0], pop_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_late();
        test_redirect_collide();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
